// File: rtl/ddr3_cmd_sched.sv
// ddr3_cmd_sched: close-page DDR3 command scheduler with round-robin
// arbitration of two requesters and periodic refresh.
module ddr3_cmd_sched #(
   parameter int T_RCD     = 6,
   parameter int T_RECOV   = 20,
   parameter int T_RFC     = 64,
   parameter int T_REFI    = 3120,
   parameter int CL        = 5,
   parameter int CWL       = 5,
   parameter int BURST_CYC = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        init_done,
   input  logic        req0_valid,
   input  logic        req0_we,
   input  logic [2:0]  req0_ba,
   input  logic [13:0] req0_row,
   input  logic [9:0]  req0_col,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic        req1_we,
   input  logic [2:0]  req1_ba,
   input  logic [13:0] req1_row,
   input  logic [9:0]  req1_col,
   output logic        req1_ready,
   output logic        done,
   output logic        done_id,
   output logic        ref_overrun,
   output logic        ddr3_cs_out,
   output logic        ddr3_ras_out,
   output logic        ddr3_cas_out,
   output logic        ddr3_we_out,
   output logic [2:0]  ddr3_ba_out,
   output logic [13:0] ddr3_addr_out,
   output logic        ddr3_pdata_write,
   output logic        ddr3_dq_oe,
   output logic        ddr3_dq_receiver_en
);

   localparam int RFW = $clog2(T_REFI);

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_RD  = 4'b0101;
   localparam logic [3:0] CMD_WR  = 4'b0100;
   localparam logic [3:0] CMD_REF = 4'b0001;

   typedef enum logic [2:0] {
      S_IDLE, S_TRCD, S_RW, S_RECOV, S_TRFC
   } state_t;

   state_t state, state_nx;
   logic [7:0] cnt, cnt_nx;
   logic [RFW-1:0] refi_cnt;
   logic ref_pending, ref_clr, wrap;
   logic rr, grant, gid;
   logic l_we, l_id;
   logic [2:0] l_ba;
   logic [9:0] l_col;
   logic [3:0] cmd_nx;
   logic [2:0] ba_nx;
   logic [13:0] addr_nx;
   logic rdy0_nx, rdy1_nx, done_nx, did_nx;
   logic pw_nx, oe_nx, rx_nx;
   int e1;

   assign wrap = init_done && (refi_cnt == '0);

   // Next-state, next-command and data-strobe decode
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      cmd_nx   = CMD_NOP;
      ba_nx    = 3'd0;
      addr_nx  = 14'd0;
      rdy0_nx  = 1'b0;
      rdy1_nx  = 1'b0;
      done_nx  = 1'b0;
      did_nx   = 1'b0;
      pw_nx    = 1'b0;
      oe_nx    = 1'b0;
      rx_nx    = 1'b0;
      ref_clr  = 1'b0;
      grant    = 1'b0;
      gid      = 1'b0;
      e1       = 0;
      unique case (state)
         S_IDLE: begin
            if (init_done && ref_pending) begin
               cmd_nx   = CMD_REF;
               ref_clr  = 1'b1;
               cnt_nx   = 8'(T_RFC - 1);
               state_nx = S_TRFC;
            end else if (init_done && (req0_valid || req1_valid)) begin
               grant    = 1'b1;
               gid      = !(req0_valid && (!rr || !req1_valid));
               cmd_nx   = CMD_ACT;
               ba_nx    = gid ? req1_ba : req0_ba;
               addr_nx  = gid ? req1_row : req0_row;
               rdy0_nx  = !gid;
               rdy1_nx  = gid;
               cnt_nx   = 8'(T_RCD - 2);
               state_nx = S_TRCD;
            end
         end
         S_TRCD: begin
            if (cnt == 8'd0) state_nx = S_RW;
            else cnt_nx = cnt - 8'd1;
         end
         S_RW: begin
            cmd_nx   = l_we ? CMD_WR : CMD_RD;
            ba_nx    = l_ba;
            // A10 = auto-precharge, A12 = BL8
            addr_nx  = {4'b0101, l_col};
            pw_nx    = l_we;
            cnt_nx   = 8'(T_RECOV);
            state_nx = S_RECOV;
         end
         S_RECOV: begin
            // e1 = cycles since the RD/WR pin cycle, one cycle ahead
            e1      = T_RECOV - int'(cnt) + 1;
            rx_nx   = !l_we && (e1 >= CL) && (e1 <= CL + BURST_CYC - 1);
            oe_nx   = l_we && (e1 >= CWL - 1) && (e1 <= CWL + BURST_CYC - 1);
            done_nx = (cnt == 8'd1);
            did_nx  = (cnt == 8'd1) && l_id;
            if (cnt == 8'd0) state_nx = S_IDLE;
            else cnt_nx = cnt - 8'd1;
         end
         S_TRFC: begin
            if (cnt == 8'd0) state_nx = S_IDLE;
            else cnt_nx = cnt - 8'd1;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // FSM state, counters, arbitration pointer and latched request
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
         cnt   <= 8'd0;
         rr    <= 1'b0;
         l_we  <= 1'b0;
         l_id  <= 1'b0;
         l_ba  <= 3'd0;
         l_col <= 10'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (grant) begin
            rr    <= !gid;
            l_id  <= gid;
            l_we  <= gid ? req1_we : req0_we;
            l_ba  <= gid ? req1_ba : req0_ba;
            l_col <= gid ? req1_col : req0_col;
         end
      end
   end

   // Refresh interval timer, pending flag and sticky overrun
   always_ff @(posedge clk) begin
      if (!rst) begin
         refi_cnt    <= RFW'(T_REFI - 1);
         ref_pending <= 1'b0;
         ref_overrun <= 1'b0;
      end else if (wrap) begin
         refi_cnt    <= RFW'(T_REFI - 1);
         ref_pending <= 1'b1;
         if (ref_pending && !ref_clr) ref_overrun <= 1'b1;
      end else begin
         if (init_done) refi_cnt <= refi_cnt - 1'b1;
         if (ref_clr) ref_pending <= 1'b0;
      end
   end

   // Registered command pins, handshakes and DQ strobes
   always_ff @(posedge clk) begin
      if (!rst) begin
         {ddr3_cs_out, ddr3_ras_out, ddr3_cas_out, ddr3_we_out} <= 4'b1111;
         ddr3_ba_out         <= 3'd0;
         ddr3_addr_out       <= 14'd0;
         req0_ready          <= 1'b0;
         req1_ready          <= 1'b0;
         done                <= 1'b0;
         done_id             <= 1'b0;
         ddr3_pdata_write    <= 1'b0;
         ddr3_dq_oe          <= 1'b0;
         ddr3_dq_receiver_en <= 1'b0;
      end else begin
         {ddr3_cs_out, ddr3_ras_out, ddr3_cas_out, ddr3_we_out} <= cmd_nx;
         ddr3_ba_out         <= ba_nx;
         ddr3_addr_out       <= addr_nx;
         req0_ready          <= rdy0_nx;
         req1_ready          <= rdy1_nx;
         done                <= done_nx;
         done_id             <= did_nx;
         ddr3_pdata_write    <= pw_nx;
         ddr3_dq_oe          <= oe_nx;
         ddr3_dq_receiver_en <= rx_nx;
      end
   end

endmodule

// File: tb/tb_ddr3_cmd_sched.sv
// tb_ddr3_cmd_sched: directed self-checking bench for ddr3_cmd_sched.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_ddr3_cmd_sched;

   logic clk = 1'b0;
   logic rst, init_done;
   logic req0_valid, req0_we, req1_valid, req1_we;
   logic [2:0] req0_ba, req1_ba;
   logic [13:0] req0_row, req1_row;
   logic [9:0] req0_col, req1_col;
   logic req0_ready, req1_ready, done, done_id, ref_overrun;
   logic cs, ras, cas, we;
   logic [2:0] ba;
   logic [13:0] addr;
   logic pw, oe, rx;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   localparam logic [3:0] DES = 4'b1111;
   localparam logic [3:0] NOP = 4'b0111;
   localparam logic [3:0] ACT = 4'b0011;
   localparam logic [3:0] RD  = 4'b0101;
   localparam logic [3:0] WR  = 4'b0100;
   localparam logic [3:0] REF = 4'b0001;

   ddr3_cmd_sched dut (
      .clk(clk), .rst(rst), .init_done(init_done),
      .req0_valid(req0_valid), .req0_we(req0_we), .req0_ba(req0_ba),
      .req0_row(req0_row), .req0_col(req0_col), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_we(req1_we), .req1_ba(req1_ba),
      .req1_row(req1_row), .req1_col(req1_col), .req1_ready(req1_ready),
      .done(done), .done_id(done_id), .ref_overrun(ref_overrun),
      .ddr3_cs_out(cs), .ddr3_ras_out(ras), .ddr3_cas_out(cas),
      .ddr3_we_out(we), .ddr3_ba_out(ba), .ddr3_addr_out(addr),
      .ddr3_pdata_write(pw), .ddr3_dq_oe(oe), .ddr3_dq_receiver_en(rx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // flags: {r0,r1,done,done_id,pdata_write,dq_oe,rx_en,ref_overrun}
   function automatic logic [28:0] obs();
      return {cs, ras, cas, we, ba, addr, req0_ready, req1_ready,
              done, done_id, pw, oe, rx, ref_overrun};
   endfunction

   function automatic logic [28:0] mk(input logic [3:0] c,
         input logic [2:0] b, input logic [13:0] a, input logic [7:0] f);
      return {c, b, a, f};
   endfunction

   task automatic test_reset();
      logic [28:0] o;
      @(negedge clk);
      rst = 1'b0; init_done = 1'b0; req0_valid = 1'b1;
      repeat (2) @(negedge clk);
      o = obs();
      checks++;
      if (o !== mk(DES, 3'd0, 14'd0, 8'h00)) begin
         failures++;
         $display("FAIL reset_values got=%h want=%h", o, mk(DES, 3'd0, 14'd0, 8'h00));
      end
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         o = obs();
         checks++;
         if (o !== mk(NOP, 3'd0, 14'd0, 8'h00)) begin
            failures++;
            $display("FAIL no_init_nop cyc%0d got=%h want=%h", i, o, mk(NOP, 3'd0, 14'd0, 8'h00));
         end
      end
      req0_valid = 1'b0;
   endtask

   task automatic test_read();
      logic [28:0] o, e;
      logic [3:0] c;
      logic [2:0] b;
      logic [13:0] a;
      logic [7:0] f;
      bit found = 0;
      init_done = 1'b1;
      req0_valid = 1'b1; req0_we = 1'b0; req0_ba = 3'd2;
      req0_row = 14'h155; req0_col = 10'h08;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if ({cs, ras, cas, we} == ACT) found = 1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL read_act_timeout got=none want=ACT");
      end
      o = obs();
      e = mk(ACT, 3'd2, 14'h155, 8'h80);
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL read_act got=%h want=%h", o, e);
      end
      req0_valid = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         c = (k == 6) ? RD : NOP;
         b = (k == 6) ? 3'd2 : 3'd0;
         a = (k == 6) ? 14'h1408 : 14'd0;
         f = 8'h00;
         if (k >= 11 && k <= 14) f = f | 8'h02;
         if (k == 26) f = f | 8'h20;
         o = obs();
         e = mk(c, b, a, f);
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL read_seq T+%0d got=%h want=%h", k, o, e);
         end
      end
   endtask

   task automatic test_write();
      logic [28:0] o, e;
      logic [3:0] c;
      logic [2:0] b;
      logic [13:0] a;
      logic [7:0] f;
      bit found = 0;
      req1_valid = 1'b1; req1_we = 1'b1; req1_ba = 3'd5;
      req1_row = 14'h2AA; req1_col = 10'h3F;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if ({cs, ras, cas, we} == ACT) found = 1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL write_act_timeout got=none want=ACT");
      end
      o = obs();
      e = mk(ACT, 3'd5, 14'h2AA, 8'h40);
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL write_act got=%h want=%h", o, e);
      end
      req1_valid = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         c = (k == 6) ? WR : NOP;
         b = (k == 6) ? 3'd5 : 3'd0;
         a = (k == 6) ? 14'h143F : 14'd0;
         f = (k == 6) ? 8'h08 : 8'h00;
         if (k >= 10 && k <= 14) f = f | 8'h04;
         if (k == 26) f = f | 8'h30;
         o = obs();
         e = mk(c, b, a, f);
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL write_seq T+%0d got=%h want=%h", k, o, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n_act = 0;
      int last_act = 0;
      logic [1:0] want;
      req0_valid = 1'b1; req0_we = 1'b0; req0_ba = 3'd1;
      req0_row = 14'h011; req0_col = 10'h010;
      req1_valid = 1'b1; req1_we = 1'b1; req1_ba = 3'd6;
      req1_row = 14'h3C3; req1_col = 10'h020;
      for (int i = 0; i < 200 && n_act < 4; i++) begin
         @(negedge clk);
         if ({cs, ras, cas, we} == ACT) begin
            want = (n_act % 2 == 0) ? 2'b10 : 2'b01;
            checks++;
            if ({req0_ready, req1_ready} !== want) begin
               failures++;
               $display("FAIL b2b_grant%0d got=%b want=%b", n_act, {req0_ready, req1_ready}, want);
            end
            if (n_act > 0) begin
               checks++;
               if (cyc - last_act != 28) begin
                  failures++;
                  $display("FAIL b2b_spacing got=%0d want=28", cyc - last_act);
               end
            end
            last_act = cyc;
            n_act++;
         end else begin
            checks++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
               failures++;
               $display("FAIL b2b_stray_ready got=%b want=00", {req0_ready, req1_ready});
            end
         end
      end
      checks++;
      if (n_act != 4) begin
         failures++;
         $display("FAIL b2b_act_count got=%0d want=4", n_act);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (40) @(negedge clk);
   endtask

   task automatic test_refresh();
      int last_done = -100;
      int ref_cyc = -1;
      bit fin = 0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1; init_done = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 3600 && !fin; i++) begin
         @(negedge clk);
         if (done === 1'b1) last_done = cyc;
         if ({cs, ras, cas, we} == REF) begin
            ref_cyc = cyc;
            checks++;
            if (cyc - last_done != 2) begin
               failures++;
               $display("FAIL ref_after_done got=%0d want=2", cyc - last_done);
            end
         end
         if ({cs, ras, cas, we} == ACT && ref_cyc >= 0) begin
            checks++;
            if (cyc - ref_cyc != 65) begin
               failures++;
               $display("FAIL ref_to_act got=%0d want=65", cyc - ref_cyc);
            end
            fin = 1;
         end
      end
      checks++;
      if (!fin) begin
         failures++;
         $display("FAIL ref_timeout got=ref_cyc%0d want=REF_then_ACT", ref_cyc);
      end
      checks++;
      if (ref_overrun !== 1'b0) begin
         failures++;
         $display("FAIL ref_overrun got=%b want=0", ref_overrun);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (70) @(negedge clk);
   endtask

   task automatic test_abort();
      logic [28:0] o, e;
      bit found = 0;
      req0_valid = 1'b1; req0_we = 1'b0; req0_ba = 3'd3;
      req0_row = 14'h0AB; req0_col = 10'h004;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if ({cs, ras, cas, we} == ACT) found = 1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL abort_act1_timeout got=none want=ACT");
      end
      @(negedge clk);
      rst = 1'b0; req1_valid = 1'b1;
      @(negedge clk);
      o = obs();
      e = mk(DES, 3'd0, 14'd0, 8'h00);
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL abort_reset got=%h want=%h", o, e);
      end
      rst = 1'b1;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if ({cs, ras, cas, we} == ACT) found = 1;
      end
      o = obs();
      e = mk(ACT, 3'd3, 14'h0AB, 8'h80);
      checks++;
      if (!found || o !== e) begin
         failures++;
         $display("FAIL abort_restart got=%h want=%h", o, e);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (30) @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; init_done = 1'b0;
      req0_valid = 1'b0; req0_we = 1'b0; req0_ba = 3'd0;
      req0_row = 14'd0; req0_col = 10'd0;
      req1_valid = 1'b0; req1_we = 1'b0; req1_ba = 3'd0;
      req1_row = 14'd0; req1_col = 10'd0;
      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      test_refresh();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
